sha1_msg_feeder: RTL and testbench

Front end for `sha1_pipe`. It accepts a message as a stream of 32-bit big-endian words, applies FIPS 180-2 padding and the 64-bit length field, and issues one 512-bit chunk at a time to the pipe. It chains the intermediate hash across chunks and returns the final 160-bit digest. It sits between the NTP payload extractor (key ‖ NTP header) and `sha1_pipe` in the packet-processing path.

---
 rtl/sha1_pkg.sv | 32 +++
 rtl/sha1_pad_insert.sv | 35 +++
 rtl/sha1_msg_feeder.sv | 241 ++++++++++++++++++++++++
 tb/tb_sha1_msg_feeder.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: chunk/digest widths, initial chaining value,
// feeder FSM states and a small byte-count helper.
package sha1_pkg;

  localparam int CHUNK_W  = 512;
  localparam int DIGEST_W = 160;

  localparam logic [31:0] H0_INIT = 32'h67452301;
  localparam logic [31:0] H1_INIT = 32'hEFCDAB89;
  localparam logic [31:0] H2_INIT = 32'h98BADCFE;
  localparam logic [31:0] H3_INIT = 32'h10325476;
  localparam logic [31:0] H4_INIT = 32'hC3D2E1F0;

  // Element i holds Hi.
  localparam logic [4:0][31:0] H_INIT = {H4_INIT, H3_INIT, H2_INIT, H1_INIT, H0_INIT};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ISSUE,
    ST_WAIT,
    ST_PADBLK
  } feeder_state_e;

  // Number of valid bytes in a final word; an encoding of 0 stands for 4.
  function automatic logic [2:0] last_byte_count(input logic [1:0] code);
    logic [2:0] n;
    n = (code == 2'd0) ? 3'd4 : {1'b0, code};
    return n;
  endfunction

endpackage

// File: rtl/sha1_pad_insert.sv
// Combinational padding stage: keeps bytes below pos, optionally places the
// 80h marker at pos, zeroes the rest and optionally writes the bit length
// into bytes 56..63.
module sha1_pad_insert
  import sha1_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic [CHUNK_W-1:0] chunk_in,
  input  logic [6:0]         pos,
  input  logic               mark_en,
  input  logic [LEN_W-1:0]   len_bytes,
  input  logic               len_en,
  output logic [CHUNK_W-1:0] chunk_out
);

  logic [63:0] bit_len;

  // Rebuild the chunk byte by byte, then overlay the 64-bit length field.
  always_comb begin
    bit_len   = 64'(len_bytes) << 3;
    chunk_out = '0;
    for (int b = 0; b < 64; b++) begin
      if (7'(b) < pos) begin
        chunk_out[CHUNK_W-1-8*b -: 8] = chunk_in[CHUNK_W-1-8*b -: 8];
      end else if ((7'(b) == pos) && mark_en) begin
        chunk_out[CHUNK_W-1-8*b -: 8] = 8'h80;
      end
    end
    if (len_en) begin
      chunk_out[63:0] = bit_len;
    end
  end

endmodule

// File: rtl/sha1_msg_feeder.sv
// SHA-1 message front end: packs big-endian words into 512-bit chunks,
// applies padding and the length field, issues chunks to sha1_pipe,
// chains the intermediate hash and returns the final digest.
module sha1_msg_feeder
  import sha1_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_data,
  input  logic                in_last,
  input  logic [1:0]          in_bytes,
  output logic                sha_start,
  output logic [CHUNK_W-1:0]  sha_chunk,
  output logic [31:0]         sha_h0,
  output logic [31:0]         sha_h1,
  output logic [31:0]         sha_h2,
  output logic [31:0]         sha_h3,
  output logic [31:0]         sha_h4,
  input  logic                sha_ready,
  input  logic [31:0]         sha_x0,
  input  logic [31:0]         sha_x1,
  input  logic [31:0]         sha_x2,
  input  logic [31:0]         sha_x3,
  input  logic [31:0]         sha_x4,
  output logic                digest_valid,
  output logic [DIGEST_W-1:0] digest
);

  feeder_state_e        state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [CHUNK_W-1:0]   chunk_q, chunk_d;
  logic [4:0][31:0]     h_q, h_d;
  logic                 final_q, final_d;
  logic                 pad_pending_q, pad_pending_d;
  logic                 owe80_q, owe80_d;
  logic                 digest_valid_q, digest_valid_d;
  logic [DIGEST_W-1:0]  digest_q, digest_d;
  logic                 ready_en_q, ready_en_d;

  logic                 accept;
  logic [3:0]           idx_eff;
  logic [LEN_W-1:0]     len_eff;
  logic [2:0]           nbytes;
  logic [6:0]           last_pos;
  logic [LEN_W-1:0]     len_inc;
  logic [CHUNK_W-1:0]   chunk_wr;
  logic [4:0][31:0]     x_in;
  logic [4:0][31:0]     h_sum;

  logic [CHUNK_W-1:0]   pad_chunk_in;
  logic [6:0]           pad_pos;
  logic                 pad_mark;
  logic [LEN_W-1:0]     pad_len;
  logic                 pad_len_en;
  logic [CHUNK_W-1:0]   pad_chunk_out;

  assign x_in = {sha_x4, sha_x3, sha_x2, sha_x1, sha_x0};

  // Ready is held low until the first clock after reset release.
  assign in_ready  = ready_en_q && ((state_q == ST_IDLE) || (state_q == ST_FILL));
  assign accept    = in_valid && in_ready;
  assign sha_start = (state_q == ST_ISSUE);

  assign sha_chunk    = chunk_q;
  assign sha_h0       = h_q[0];
  assign sha_h1       = h_q[1];
  assign sha_h2       = h_q[2];
  assign sha_h3       = h_q[3];
  assign sha_h4       = h_q[4];
  assign digest_valid = digest_valid_q;
  assign digest       = digest_q;

  // Word write position, running length and chaining sums; IDLE behaves as a
  // freshly cleared index/length even on its first cycle.
  always_comb begin
    idx_eff  = (state_q == ST_IDLE) ? 4'd0 : idx_q;
    len_eff  = (state_q == ST_IDLE) ? '0 : len_q;
    nbytes   = last_byte_count(in_bytes);
    last_pos = {1'b0, idx_eff, 2'b00} + {4'b0000, nbytes};
    len_inc  = len_eff + (in_last ? LEN_W'(nbytes) : LEN_W'(4));
    chunk_wr = chunk_q;
    for (int i = 0; i < 16; i++) begin
      if (idx_eff == 4'(i)) begin
        chunk_wr[CHUNK_W-1-32*i -: 32] = in_data;
      end
    end
    for (int i = 0; i < 5; i++) begin
      h_sum[i] = h_q[i] + x_in[i];
    end
  end

  // The padding stage is shared: the last data word in FILL, or an empty chunk in PADBLK.
  always_comb begin
    if (state_q == ST_PADBLK) begin
      pad_chunk_in = '0;
      pad_pos      = 7'd0;
      pad_mark     = owe80_q;
      pad_len      = len_q;
      pad_len_en   = 1'b1;
    end else begin
      pad_chunk_in = chunk_wr;
      pad_pos      = last_pos;
      pad_mark     = 1'b1;
      pad_len      = len_inc;
      pad_len_en   = (last_pos <= 7'd55);
    end
  end

  sha1_pad_insert #(
    .LEN_W(LEN_W)
  ) u_pad (
    .chunk_in (pad_chunk_in),
    .pos      (pad_pos),
    .mark_en  (pad_mark),
    .len_bytes(pad_len),
    .len_en   (pad_len_en),
    .chunk_out(pad_chunk_out)
  );

  // Next-state logic for the message/chunk sequencing and chaining registers.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    len_d          = len_q;
    chunk_d        = chunk_q;
    h_d            = h_q;
    final_d        = final_q;
    pad_pending_d  = pad_pending_q;
    owe80_d        = owe80_q;
    digest_d       = digest_q;
    digest_valid_d = 1'b0;
    ready_en_d     = 1'b1;

    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (state_q == ST_IDLE) begin
          h_d           = H_INIT;
          idx_d         = 4'd0;
          len_d         = '0;
          final_d       = 1'b0;
          pad_pending_d = 1'b0;
          owe80_d       = 1'b0;
        end
        if (accept) begin
          idx_d = idx_eff + 4'd1;
          len_d = len_inc;
          if (in_last) begin
            chunk_d = pad_chunk_out;
            state_d = ST_ISSUE;
            if (last_pos <= 7'd55) begin
              final_d       = 1'b1;
              pad_pending_d = 1'b0;
              owe80_d       = 1'b0;
            end else begin
              final_d       = 1'b0;
              pad_pending_d = 1'b1;
              owe80_d       = (last_pos == 7'd64);
            end
          end else begin
            chunk_d = chunk_wr;
            if (idx_eff == 4'd15) begin
              state_d       = ST_ISSUE;
              final_d       = 1'b0;
              pad_pending_d = 1'b0;
              owe80_d       = 1'b0;
            end else begin
              state_d = ST_FILL;
            end
          end
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (sha_ready) begin
          h_d = h_sum;
          if (final_q) begin
            digest_d       = {h_sum[0], h_sum[1], h_sum[2], h_sum[3], h_sum[4]};
            digest_valid_d = 1'b1;
            state_d        = ST_IDLE;
          end else if (pad_pending_q) begin
            state_d = ST_PADBLK;
          end else begin
            idx_d   = 4'd0;
            state_d = ST_FILL;
          end
        end
      end

      ST_PADBLK: begin
        chunk_d       = pad_chunk_out;
        final_d       = 1'b1;
        pad_pending_d = 1'b0;
        owe80_d       = 1'b0;
        state_d       = ST_ISSUE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial message.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= ST_IDLE;
      idx_q          <= 4'd0;
      len_q          <= '0;
      chunk_q        <= '0;
      h_q            <= H_INIT;
      final_q        <= 1'b0;
      pad_pending_q  <= 1'b0;
      owe80_q        <= 1'b0;
      digest_valid_q <= 1'b0;
      digest_q       <= '0;
      ready_en_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
      chunk_q        <= chunk_d;
      h_q            <= h_d;
      final_q        <= final_d;
      pad_pending_q  <= pad_pending_d;
      owe80_q        <= owe80_d;
      digest_valid_q <= digest_valid_d;
      digest_q       <= digest_d;
      ready_en_q     <= ready_en_d;
    end
  end

endmodule

// File: tb/tb_sha1_msg_feeder.sv
// Self-checking bench for sha1_msg_feeder with a behavioural SHA-1 pipe and
// a byte-level padding/digest reference model.
module tb_sha1_msg_feeder;

  logic         clk = 1'b0;
  logic         aresetn;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [1:0]   in_bytes;
  logic         sha_start;
  logic [511:0] sha_chunk;
  logic [31:0]  sha_h0, sha_h1, sha_h2, sha_h3, sha_h4;
  logic         sha_ready;
  logic [31:0]  sha_x0, sha_x1, sha_x2, sha_x3, sha_x4;
  logic         digest_valid;
  logic [159:0] digest;

  localparam logic [159:0] H_START = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  int tests_run    = 0;
  int tests_failed = 0;

  int cyc = 0;
  int acc_cnt = 0;
  int acc_base = 0;
  int last_ready_cyc = 0;
  int dv_cyc = 0;
  bit force_ready = 1'b0;
  bit pipe_busy = 1'b0;
  int pipe_cnt = 0;
  logic [511:0] cap_chunk;
  logic [159:0] cap_h;
  logic [159:0] pipe_res;

  logic [7:0]   msg_q[$];
  logic [511:0] chunk_log[$];
  int           start_acc[$];
  logic [511:0] exp_chunks[$];
  logic [159:0] exp_digest;

  sha1_msg_feeder dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_bytes    (in_bytes),
    .sha_start   (sha_start),
    .sha_chunk   (sha_chunk),
    .sha_h0      (sha_h0),
    .sha_h1      (sha_h1),
    .sha_h2      (sha_h2),
    .sha_h3      (sha_h3),
    .sha_h4      (sha_h4),
    .sha_ready   (sha_ready),
    .sha_x0      (sha_x0),
    .sha_x1      (sha_x1),
    .sha_x2      (sha_x2),
    .sha_x3      (sha_x3),
    .sha_x4      (sha_x4),
    .digest_valid(digest_valid),
    .digest      (digest)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Count words that the next rising edge will accept.
  always @(negedge clk) begin
    if (aresetn && in_valid && in_ready) acc_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 80 SHA-1 rounds, returning a..e before the feed-forward addition.
  function automatic logic [159:0] sha1Rounds(input logic [511:0] blk, input logic [159:0] h);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t, s;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      s = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {s[30:0], s[31]};
    end
    {a, b, c, d, e} = h;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {a, b, c, d, e};
  endfunction

  // Behavioural sha1_pipe: 26-cycle latency, returns working variables.
  always @(posedge clk) begin
    #1;
    sha_ready = 1'b0;
    if (!aresetn) begin
      pipe_busy = 1'b0;
    end else if (pipe_busy) begin
      pipe_cnt--;
      if (pipe_cnt == 25) checkOutput("start_one_cycle", sha_start, 0);
      if (pipe_cnt == 13) checkOutput("ready_low_in_wait", in_ready, 0);
      if (pipe_cnt == 0) begin
        checkOutput("chunk_held", sha_chunk, cap_chunk);
        checkOutput("h_held", {sha_h0, sha_h1, sha_h2, sha_h3, sha_h4}, cap_h);
        {sha_x0, sha_x1, sha_x2, sha_x3, sha_x4} = pipe_res;
        sha_ready = 1'b1;
        pipe_busy = 1'b0;
        last_ready_cyc = cyc;
      end
    end else if (sha_start) begin
      cap_chunk = sha_chunk;
      cap_h     = {sha_h0, sha_h1, sha_h2, sha_h3, sha_h4};
      pipe_res  = sha1Rounds(cap_chunk, cap_h);
      chunk_log.push_back(cap_chunk);
      start_acc.push_back(acc_cnt);
      checkOutput("ready_low_in_issue", in_ready, 0);
      pipe_cnt  = 26;
      pipe_busy = 1'b1;
    end
    if (force_ready) sha_ready = 1'b1;
  end

  // Reference: pad the byte string, split into chunks, chain the hash.
  task automatic buildExpected();
    logic [7:0]   pad[$];
    logic [63:0]  bitlen;
    logic [511:0] blk;
    logic [159:0] h, r;
    pad = msg_q;
    bitlen = 64'(msg_q.size()) * 64'd8;
    pad.push_back(8'h80);
    while ((pad.size() % 64) != 56) pad.push_back(8'h00);
    for (int i = 7; i >= 0; i--) pad.push_back(8'(bitlen >> (8*i)));
    exp_chunks.delete();
    h = H_START;
    for (int c = 0; c < pad.size() / 64; c++) begin
      for (int b = 0; b < 64; b++) blk[511-8*b -: 8] = pad[c*64+b];
      exp_chunks.push_back(blk);
      r = sha1Rounds(blk, h);
      for (int j = 0; j < 5; j++) h[159-32*j -: 32] = h[159-32*j -: 32] + r[159-32*j -: 32];
    end
    exp_digest = h;
  endtask

  task automatic setString(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endtask

  task automatic setRandom(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  // Stream msg_q as big-endian words; unused bytes of the last word are junk.
  task automatic applyStimulus(input bit gaps);
    int n, nw, nb, g, t;
    logic [31:0] d;
    n  = msg_q.size();
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      d  = $urandom;
      nb = (w == nw - 1) ? n - 4*w : 4;
      for (int b = 0; b < nb; b++) d[31-8*b -: 8] = msg_q[4*w+b];
      if (gaps) begin
        g = $urandom_range(0, 2);
        if (g > 0) begin
          in_valid = 1'b0;
          repeat (g) begin @(posedge clk); #1; end
        end
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = (w == nw - 1);
      in_bytes = in_last ? 2'(nb % 4) : 2'($urandom);
      t = 0;
      while (!in_ready && t < 500) begin @(posedge clk); #1; t++; end
      if (!in_ready) begin
        checkOutput("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitDigest(output logic [159:0] dig, output bit ok);
    int n;
    ok = 1'b0;
    dig = '0;
    n = 0;
    while (n < 4000 && !ok) begin
      @(posedge clk); #2;
      if (digest_valid) begin
        ok = 1'b1;
        dig = digest;
        dv_cyc = cyc;
      end
      n++;
    end
  endtask

  task automatic runMessage(input string name, input bit gaps);
    logic [159:0] dig;
    bit ok;
    int m;
    buildExpected();
    chunk_log.delete();
    start_acc.delete();
    acc_base = acc_cnt;
    applyStimulus(gaps);
    waitDigest(dig, ok);
    checkOutput({name, "_done"}, ok, 1);
    if (ok) begin
      checkOutput({name, "_digest"}, dig, exp_digest);
      checkOutput({name, "_dv_latency"}, dv_cyc - last_ready_cyc, 1);
      checkOutput({name, "_nchunks"}, chunk_log.size(), exp_chunks.size());
      m = (chunk_log.size() < exp_chunks.size()) ? chunk_log.size() : exp_chunks.size();
      for (int i = 0; i < m; i++)
        checkOutput($sformatf("%s_chunk%0d", name, i), chunk_log[i], exp_chunks[i]);
      @(posedge clk); #2;
      checkOutput({name, "_dv_pulse"}, digest_valid, 0);
      checkOutput({name, "_digest_hold"}, digest, dig);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t;
    bit seen;
    aresetn  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    in_bytes = '0;
    sha_ready = 1'b0;
    {sha_x0, sha_x1, sha_x2, sha_x3, sha_x4} = '0;

    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_sha_start", sha_start, 0);
    checkOutput("rst_sha_chunk", sha_chunk, 0);
    checkOutput("rst_sha_h", {sha_h0, sha_h1, sha_h2, sha_h3, sha_h4}, H_START);
    checkOutput("rst_digest_valid", digest_valid, 0);
    checkOutput("rst_digest", digest, 0);
    aresetn = 1'b1;
    #1;
    checkOutput("ready_low_before_edge", in_ready, 0);
    @(posedge clk); #2;
    checkOutput("ready_after_reset", in_ready, 1);

    setString("abc");
    runMessage("abc", 1'b1);
    checkOutput("abc_digest_const", digest, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);
    checkOutput("abc_chunk_const", chunk_log[0], {32'h61626380, 416'h0, 64'h18});

    setString("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    runMessage("msg56", 1'b1);
    checkOutput("msg56_digest_const", digest, 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1);
    if (chunk_log.size() == 2) begin
      checkOutput("msg56_c0_tail", chunk_log[0][63:0], 64'h80000000_00000000);
      checkOutput("msg56_c1", chunk_log[1], {448'h0, 64'h1C0});
    end

    setRandom(64);
    runMessage("msg64", 1'b1);
    if (chunk_log.size() == 2) begin
      checkOutput("msg64_c1_head", chunk_log[1][511:480], 32'h80000000);
      checkOutput("msg64_c1_len", chunk_log[1][63:0], 64'h200);
    end

    setRandom(55);
    runMessage("msg55", 1'b1);
    if (chunk_log.size() == 1) begin
      checkOutput("msg55_byte55", chunk_log[0][71:64], 8'h80);
      checkOutput("msg55_len", chunk_log[0][63:0], 64'h1B8);
    end

    setRandom(80);
    runMessage("bp80", 1'b0);
    checkOutput("bp_starts", start_acc.size(), 2);
    if (start_acc.size() == 2) begin
      checkOutput("bp_words_before_first", start_acc[0] - acc_base, 16);
      checkOutput("bp_words_total", start_acc[1] - acc_base, 20);
    end

    // Reset while the pipe is working on a chunk.
    setString("abc");
    applyStimulus(1'b0);
    t = 0;
    while (!pipe_busy && t < 100) begin @(posedge clk); #2; t++; end
    checkOutput("mid_wait_reached", pipe_busy, 1);
    repeat (5) @(posedge clk);
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", in_ready, 0);
    checkOutput("mid_rst_sha_start", sha_start, 0);
    checkOutput("mid_rst_sha_chunk", sha_chunk, 0);
    checkOutput("mid_rst_sha_h", {sha_h0, sha_h1, sha_h2, sha_h3, sha_h4}, H_START);
    checkOutput("mid_rst_digest_valid", digest_valid, 0);
    checkOutput("mid_rst_digest", digest, 0);
    repeat (2) @(posedge clk);
    #2;
    aresetn = 1'b1;
    @(posedge clk); #2;
    checkOutput("mid_rst_ready_back", in_ready, 1);
    @(negedge clk) force_ready = 1'b1;
    @(negedge clk) force_ready = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #2;
      if (digest_valid) seen = 1'b1;
    end
    checkOutput("late_ready_no_digest", seen, 0);
    checkOutput("late_ready_h", {sha_h0, sha_h1, sha_h2, sha_h3, sha_h4}, H_START);
    checkOutput("late_ready_digest", digest, 0);

    setString("abc");
    runMessage("abc_after_rst", 1'b1);
    checkOutput("abc_after_rst_const", digest, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);

    for (int r = 0; r < 8; r++) begin
      case (r)
        0: setRandom(60);
        1: setRandom(63);
        2: setRandom(128);
        3: setRandom(119);
        default: setRandom($urandom_range(1, 200));
      endcase
      runMessage($sformatf("rand%0d_len%0d", r, msg_q.size()), r[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
